// File: rtl/down_demux_1to4.sv
// Hub-to-client return path: shared flit FIFO steering head flits to four local
// clients, with credit pulses back to the hub and per-client credit counters.
module down_demux_1to4 #(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned CLIENT_CREDITS = 4,
  parameter int unsigned DST_LSB        = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] hub_out_data,
  input  logic        hub_out_valid,
  output logic        hub_ci,
  output logic [19:0] c_data0,
  output logic [19:0] c_data1,
  output logic [19:0] c_data2,
  output logic [19:0] c_data3,
  output logic        c_vld0,
  output logic        c_vld1,
  output logic        c_vld2,
  output logic        c_vld3,
  input  logic        c_cred0,
  input  logic        c_cred1,
  input  logic        c_cred2,
  input  logic        c_cred3,
  output logic        ovf_err
);

  localparam int unsigned FW = 20;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = 3;
  localparam int unsigned NC = 4;

  logic [FW-1:0] mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0]   pend_q, pend_d;
  logic [CW-1:0] cred_q [NC];
  logic [CW-1:0] cred_d [NC];
  logic [FW-1:0] data_q [NC];
  logic [FW-1:0] data_d [NC];
  logic [NC-1:0] vld_q, vld_d;
  logic          ci_q, ci_d;
  logic          ovf_q, ovf_d;

  logic [NC-1:0] cred_in;
  logic [FW-1:0] head_flit;
  logic [1:0]    dst;
  logic          enq;
  logic          disp;

  // Next-state: enqueue/overflow, head dispatch, credit accounting
  always_comb begin
    cred_in   = {c_cred3, c_cred2, c_cred1, c_cred0};
    head_flit = mem_q[head_q];
    dst       = head_flit[DST_LSB+1:DST_LSB];
    enq       = hub_out_valid && (pend_q != (PW+1)'(DEPTH));
    disp      = (pend_q != '0) && (cred_q[dst] != '0);

    head_d = head_q;
    tail_d = tail_q;
    pend_d = pend_q;
    data_d = data_q;
    cred_d = cred_q;
    vld_d  = '0;
    ci_d   = 1'b0;
    ovf_d  = ovf_q | (hub_out_valid & ~enq);

    if (enq) begin
      tail_d = tail_q + PW'(1);
    end
    if (disp) begin
      head_d      = head_q + PW'(1);
      data_d[dst] = head_flit;
      vld_d[dst]  = 1'b1;
      ci_d        = 1'b1;
    end

    case ({enq, disp})
      2'b10:   pend_d = pend_q + (PW+1)'(1);
      2'b01:   pend_d = pend_q - (PW+1)'(1);
      default: pend_d = pend_q;
    endcase

    // A return and a dispatch to the same client in one cycle cancel out
    for (int n = 0; n < int'(NC); n++) begin
      if (cred_in[n] && !(disp && dst == 2'(n))) begin
        if (cred_q[n] != CW'(CLIENT_CREDITS)) cred_d[n] = cred_q[n] + CW'(1);
      end else if (!cred_in[n] && disp && dst == 2'(n)) begin
        cred_d[n] = cred_q[n] - CW'(1);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      pend_q <= '0;
      vld_q  <= '0;
      ci_q   <= 1'b0;
      ovf_q  <= 1'b0;
      for (int n = 0; n < int'(NC); n++) begin
        cred_q[n] <= CW'(CLIENT_CREDITS);
        data_q[n] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      pend_q <= pend_d;
      vld_q  <= vld_d;
      ci_q   <= ci_d;
      ovf_q  <= ovf_d;
      cred_q <= cred_d;
      data_q <= data_d;
    end
  end

  // Flit storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (enq) mem_q[tail_q] <= hub_out_data;
  end

  assign hub_ci  = ci_q;
  assign ovf_err = ovf_q;
  assign c_data0 = data_q[0];
  assign c_data1 = data_q[1];
  assign c_data2 = data_q[2];
  assign c_data3 = data_q[3];
  assign c_vld0  = vld_q[0];
  assign c_vld1  = vld_q[1];
  assign c_vld2  = vld_q[2];
  assign c_vld3  = vld_q[3];

endmodule

// File: tb/tb_down_demux_1to4.sv
// Self-checking bench for down_demux_1to4: directed scenarios plus a random
// stream, compared each cycle against a queue-based reference model.
module tb_down_demux_1to4;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] hub_out_data;
  logic        hub_out_valid;
  logic        hub_ci;
  logic [19:0] c_data0, c_data1, c_data2, c_data3;
  logic        c_vld0, c_vld1, c_vld2, c_vld3;
  logic [3:0]  cr;
  logic        ovf_err;

  int n_assert = 0;
  int n_fail   = 0;

  down_demux_1to4 dut (
    .clk(clk), .rst(rst),
    .hub_out_data(hub_out_data), .hub_out_valid(hub_out_valid),
    .hub_ci(hub_ci),
    .c_data0(c_data0), .c_data1(c_data1), .c_data2(c_data2), .c_data3(c_data3),
    .c_vld0(c_vld0), .c_vld1(c_vld1), .c_vld2(c_vld2), .c_vld3(c_vld3),
    .c_cred0(cr[0]), .c_cred1(cr[1]), .c_cred2(cr[2]), .c_cred3(cr[3]),
    .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  // Reference model: flit queue, integer credits, expected registered outputs
  logic [19:0] q[$];
  int          m_cred[4];
  logic [19:0] m_data[4];
  logic [3:0]  m_vld;
  logic        m_ci;
  logic        m_ovf;
  int          n_ci_seen, n_disp_exp;

  task automatic model_reset();
    q.delete();
    for (int n = 0; n < 4; n++) begin
      m_cred[n] = 4;
      m_data[n] = '0;
    end
    m_vld = '0;
    m_ci  = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [19:0] d, input logic [3:0] c);
    int size0;
    int dst;
    size0 = q.size();
    m_vld = '0;
    m_ci  = 1'b0;
    if (size0 > 0) begin
      dst = int'(q[0][17:16]);
      if (m_cred[dst] > 0) begin
        m_data[dst] = q.pop_front();
        m_vld[dst]  = 1'b1;
        m_ci        = 1'b1;
        m_cred[dst] = m_cred[dst] - 1;
        n_disp_exp++;
      end
    end
    for (int n = 0; n < 4; n++)
      if (c[n]) m_cred[n] = (m_cred[n] + 1 > 4) ? 4 : m_cred[n] + 1;
    if (v) begin
      if (size0 == 8) m_ovf = 1'b1;
      else q.push_back(d);
    end
  endtask

  task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " c_vld"}, 20'({c_vld3, c_vld2, c_vld1, c_vld0}), 20'(m_vld));
    chk({tag, " hub_ci"}, 20'(hub_ci), 20'(m_ci));
    chk({tag, " ovf_err"}, 20'(ovf_err), 20'(m_ovf));
    chk({tag, " c_data0"}, c_data0, m_data[0]);
    chk({tag, " c_data1"}, c_data1, m_data[1]);
    chk({tag, " c_data2"}, c_data2, m_data[2]);
    chk({tag, " c_data3"}, c_data3, m_data[3]);
  endtask

  // Called at a falling edge: drive inputs, predict, check after next rising edge
  task automatic tick(input string tag, input logic v, input logic [19:0] d, input logic [3:0] c);
    hub_out_valid = v;
    hub_out_data  = d;
    cr            = c;
    model_step(v, d, c);
    @(negedge clk);
    if (hub_ci) n_ci_seen++;
    check_all(tag);
  endtask

  function automatic logic [19:0] mkflit(input int dst);
    logic [19:0] f;
    f = 20'($urandom);
    f[17:16] = 2'(dst);
    return f;
  endfunction

  initial begin
    n_ci_seen = 0;
    n_disp_exp = 0;
    rst = 1'b0;
    hub_out_valid = 1'b0;
    hub_out_data = '0;
    cr = '0;
    model_reset();
    #1 check_all("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // One flit per client on consecutive cycles
    tick("basic", 1'b1, 20'h00001, 4'h0);
    tick("basic", 1'b1, 20'h10002, 4'h0);
    tick("basic", 1'b1, 20'h20003, 4'h0);
    tick("basic", 1'b1, 20'h30004, 4'h0);
    repeat (3) tick("basic_idle", 1'b0, '0, 4'h0);
    tick("restore", 1'b0, '0, 4'hF);

    // Six flits to client 1 with no returns; then two single credits
    for (int i = 0; i < 6; i++) tick("cred1", 1'b1, mkflit(1), 4'h0);
    repeat (3) tick("cred1_block", 1'b0, '0, 4'h0);
    tick("cred1_ret", 1'b0, '0, 4'b0010);
    tick("cred1_ret", 1'b0, '0, 4'h0);
    tick("cred1_ret", 1'b0, '0, 4'b0010);
    repeat (2) tick("cred1_ret", 1'b0, '0, 4'h0);
    repeat (4) tick("restore", 1'b0, '0, 4'b0010);

    // Head-of-line blocking: exhaust client 0, then dst0 ahead of dst2
    for (int i = 0; i < 4; i++) tick("hol_drain", 1'b1, mkflit(0), 4'h0);
    tick("hol", 1'b1, mkflit(0), 4'h0);
    tick("hol", 1'b1, mkflit(2), 4'h0);
    repeat (3) tick("hol_block", 1'b0, '0, 4'h0);
    tick("hol_ret", 1'b0, '0, 4'b0001);
    repeat (3) tick("hol_ret", 1'b0, '0, 4'h0);
    repeat (4) tick("restore", 1'b0, '0, 4'b0001);

    // Exhaust all clients, fill the FIFO, overflow, then release
    for (int i = 0; i < 16; i++) tick("fill_drain", 1'b1, mkflit(i % 4), 4'h0);
    tick("fill_drain", 1'b0, '0, 4'h0);
    for (int i = 0; i < 8; i++) tick("fill", 1'b1, mkflit(int'($urandom_range(0, 3))), 4'h0);
    tick("ovf", 1'b1, mkflit(2), 4'h0);
    repeat (2) tick("ovf_sticky", 1'b0, '0, 4'h0);
    repeat (12) tick("release", 1'b0, '0, 4'hF);

    // Park five flits behind an exhausted client, then reset mid-stream
    for (int i = 0; i < 9; i++) tick("pend5", 1'b1, mkflit(0), 4'h0);
    repeat (2) tick("pend5", 1'b0, '0, 4'h0);
    rst = 1'b0;
    model_reset();
    #1 check_all("mid_reset");
    @(negedge clk);
    check_all("mid_reset_hold");
    rst = 1'b1;
    tick("post_reset", 1'b1, mkflit(3), 4'h0);
    repeat (2) tick("post_reset", 1'b0, '0, 4'h0);

    // Wrap: 20 round-robin flits with credit returned every cycle
    for (int i = 0; i < 20; i++) tick("wrap", 1'b1, mkflit(i % 4), 4'hF);
    repeat (3) tick("wrap_idle", 1'b0, '0, 4'hF);

    // Random traffic, valid and credit returns both random
    for (int i = 0; i < 300; i++)
      tick("rand", 1'($urandom_range(0, 1)), mkflit(int'($urandom_range(0, 3))),
           4'($urandom));
    repeat (12) tick("rand_drain", 1'b0, '0, 4'hF);

    n_assert++;
    assert (n_ci_seen === n_disp_exp) else begin
      n_fail++;
      $error("FAIL hub_ci_count: got %0d expected %0d", n_ci_seen, n_disp_exp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
